// File: rtl/wb_byte_sequencer_pkg.sv
// Shared types and bus constants for the 32-to-8 bit Wishbone byte sequencer.
package wb_byte_sequencer_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } resp_t;

endpackage

// File: rtl/wb_byte_sequencer_lane_pick.sv
// Picks the pending byte lane with the lowest byte address from a lane mask.
module wb_byte_lane_pick #(
    parameter string endian = "big"
) (
    input  logic [3:0] mask,
    output logic [1:0] lane,
    output logic [1:0] offset,
    output logic       last
);

    localparam bit LITTLE = (endian == "little");

    logic [1:0] cand;

    // Scan from the highest offset down so the lowest set offset is what remains.
    always_comb begin
        lane   = 2'd0;
        offset = 2'd0;
        cand   = 2'd0;
        for (int o = 3; o >= 0; o--) begin
            cand = LITTLE ? 2'(o) : 2'(3 - o);
            if (mask[cand]) begin
                lane   = cand;
                offset = 2'(o);
            end
        end
    end

    assign last = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);

endmodule

// File: rtl/wb_byte_sequencer.sv
// Wishbone 32-bit master to 8-bit slave converter: one slave access per selected byte lane.
module wb_byte_sequencer
    import wb_byte_sequencer_pkg::*;
#(
    parameter int    aw     = 32,
    parameter string endian = "big"
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    state_t        state_q, state_d;
    resp_t         resp_d;
    logic [aw-1:2] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   rbuf_q, rbuf_d;
    logic [1:0]    lane_q;
    logic          last_q;

    logic [1:0]    nxt_lane;
    logic [1:0]    nxt_offset;
    logic          nxt_last;

    logic          unused_inputs;
    assign unused_inputs = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

    // Lane selection looks at the next mask so slave address/data are registered in time.
    wb_byte_lane_pick #(
        .endian (endian)
    ) u_pick (
        .mask   (mask_d),
        .lane   (nxt_lane),
        .offset (nxt_offset),
        .last   (nxt_last)
    );

    assign wbs_cyc_o = (state_q == BUS) && wbm_cyc_i;
    assign wbs_stb_o = wbs_cyc_o;
    assign wbs_cti_o = CTI_CLASSIC;
    assign wbs_bte_o = BTE_LINEAR;

    always_comb begin
        state_d = state_q;
        resp_d  = RESP_ACK;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        mask_d  = mask_q;
        rbuf_d  = rbuf_q;
        unique case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_d   = wbm_adr_i[aw-1:2];
                    dat_d   = wbm_dat_i;
                    we_d    = wbm_we_i;
                    mask_d  = wbm_sel_i;
                    rbuf_d  = 32'd0;
                    state_d = (wbm_sel_i != 4'd0) ? BUS : RESP;
                end
            end
            BUS: begin
                if (!wbm_cyc_i) begin
                    mask_d  = 4'd0;
                    rbuf_d  = 32'd0;
                    state_d = IDLE;
                end else if (wbs_err_i) begin
                    mask_d  = 4'd0;
                    resp_d  = RESP_ERR;
                    state_d = RESP;
                end else if (wbs_rty_i) begin
                    mask_d  = 4'd0;
                    resp_d  = RESP_RTY;
                    state_d = RESP;
                end else if (wbs_ack_i) begin
                    rbuf_d[{lane_q, 3'b000} +: 8] = wbs_dat_i;
                    mask_d[lane_q]                = 1'b0;
                    if (last_q) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            mask_q    <= '0;
            rbuf_q    <= '0;
            lane_q    <= '0;
            last_q    <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_we_o  <= 1'b0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            mask_q    <= mask_d;
            rbuf_q    <= rbuf_d;
            lane_q    <= nxt_lane;
            last_q    <= nxt_last;
            wbs_adr_o <= {adr_d, nxt_offset};
            wbs_dat_o <= dat_d[{nxt_lane, 3'b000} +: 8];
            wbs_we_o  <= we_d;
            wbm_ack_o <= (state_d == RESP) && (resp_d == RESP_ACK);
            wbm_err_o <= (state_d == RESP) && (resp_d == RESP_ERR);
            wbm_rty_o <= (state_d == RESP) && (resp_d == RESP_RTY);
            // Read data is only presented with the response; it holds otherwise.
            if (state_d == RESP) begin
                wbm_dat_o <= rbuf_d;
            end
        end
    end

endmodule

// File: tb/tb_wb_byte_sequencer.sv
// Directed bench for wb_byte_sequencer: one big-endian and one little-endian instance on shared stimulus.
module tb_wb_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [7:0]  s_dat;
    logic        s_ack, s_err, s_rty;

    logic [31:0] be_m_dat, le_m_dat, be_s_adr, le_s_adr;
    logic        be_m_ack, be_m_err, be_m_rty, le_m_ack, le_m_err, le_m_rty;
    logic [7:0]  be_s_dat, le_s_dat;
    logic        be_s_we, be_s_cyc, be_s_stb, le_s_we, le_s_cyc, le_s_stb;
    logic [2:0]  be_s_cti, le_s_cti;
    logic [1:0]  be_s_bte, le_s_bte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_byte_sequencer #(.aw(32), .endian("big")) dut_be (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .wbm_adr_i(m_adr),    .wbm_dat_i (m_dat),    .wbm_sel_i(m_sel),
        .wbm_we_i (m_we),     .wbm_cyc_i (m_cyc),    .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti),    .wbm_bte_i (m_bte),
        .wbm_dat_o(be_m_dat), .wbm_ack_o (be_m_ack), .wbm_err_o(be_m_err), .wbm_rty_o(be_m_rty),
        .wbs_adr_o(be_s_adr), .wbs_dat_o (be_s_dat), .wbs_we_o (be_s_we),
        .wbs_cyc_o(be_s_cyc), .wbs_stb_o (be_s_stb), .wbs_cti_o(be_s_cti), .wbs_bte_o(be_s_bte),
        .wbs_dat_i(s_dat),    .wbs_ack_i (s_ack),    .wbs_err_i(s_err),    .wbs_rty_i(s_rty)
    );

    wb_byte_sequencer #(.aw(32), .endian("little")) dut_le (
        .wb_clk_i (clk),      .wb_rst_ni (rst_n),
        .wbm_adr_i(m_adr),    .wbm_dat_i (m_dat),    .wbm_sel_i(m_sel),
        .wbm_we_i (m_we),     .wbm_cyc_i (m_cyc),    .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti),    .wbm_bte_i (m_bte),
        .wbm_dat_o(le_m_dat), .wbm_ack_o (le_m_ack), .wbm_err_o(le_m_err), .wbm_rty_o(le_m_rty),
        .wbs_adr_o(le_s_adr), .wbs_dat_o (le_s_dat), .wbs_we_o (le_s_we),
        .wbs_cyc_o(le_s_cyc), .wbs_stb_o (le_s_stb), .wbs_cti_o(le_s_cti), .wbs_bte_o(le_s_bte),
        .wbs_dat_i(s_dat),    .wbs_ack_i (s_ack),    .wbs_err_i(s_err),    .wbs_rty_i(s_rty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_master();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rty = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cti = 3'b111; m_bte = 2'b11;
        s_dat = '0;
        idle_master();
        #3;
        checks++;
        if ({be_m_dat, be_m_ack, be_m_err, be_m_rty, be_s_adr, be_s_dat, be_s_we, be_s_cyc, be_s_stb, be_s_cti, be_s_bte} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got dat %h ack %b adr %h sdat %h cyc %b cti %b bte %b, want all 0",
                     be_m_dat, be_m_ack, be_s_adr, be_s_dat, be_s_cyc, be_s_cti, be_s_bte);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (be_s_cyc !== 1'b0 || be_m_ack !== 1'b0 || le_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got cyc %b ack %b le_cyc %b, want 0 0 0", be_s_cyc, be_m_ack, le_s_cyc);
        end
    endtask

    task automatic test_be_write();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        m_adr = 32'h100; m_dat = 32'hAABBCCDD; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (be_s_adr !== 32'h100 + i || be_s_dat !== exp_b[i] || be_s_cyc !== 1'b1 || be_s_stb !== 1'b1 || be_s_we !== 1'b1) begin
                errors++;
                $display("FAIL be_write_beat%0d got adr %h dat %h cyc %b stb %b we %b, want adr %h dat %h cyc 1 stb 1 we 1",
                         i, be_s_adr, be_s_dat, be_s_cyc, be_s_stb, be_s_we, 32'h100 + i, exp_b[i]);
            end
            checks++;
            if (be_m_ack !== 1'b0) begin
                errors++;
                $display("FAIL be_write_early_ack beat%0d got %b want 0", i, be_m_ack);
            end
            tick();
        end
        checks++;
        if (be_m_ack !== 1'b1 || be_m_err !== 1'b0 || be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL be_write_ack got ack %b err %b cyc %b, want 1 0 0", be_m_ack, be_m_err, be_s_cyc);
        end
        idle_master();
        tick();
        checks++;
        if (be_m_ack !== 1'b0) begin
            errors++;
            $display("FAIL be_write_ack_pulse got %b want 0", be_m_ack);
        end
    endtask

    task automatic test_le_read();
        m_adr = 32'h20; m_sel = 4'b0110; m_we = 1'b0; m_dat = 32'hFFFFFFFF;
        m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        checks++;
        if (le_s_adr !== 32'h21 || le_s_cyc !== 1'b1 || le_s_we !== 1'b0) begin
            errors++;
            $display("FAIL le_read_first got adr %h cyc %b we %b, want 21 1 0", le_s_adr, le_s_cyc, le_s_we);
        end
        s_dat = 8'h11; s_ack = 1'b1;
        tick();
        checks++;
        if (le_s_adr !== 32'h22 || le_m_ack !== 1'b0) begin
            errors++;
            $display("FAIL le_read_second got adr %h ack %b, want 22 0", le_s_adr, le_m_ack);
        end
        s_dat = 8'h22;
        tick();
        checks++;
        if (le_m_ack !== 1'b1 || le_m_dat !== 32'h00221100 || le_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL le_read_data got ack %b dat %h cyc %b, want 1 00221100 0", le_m_ack, le_m_dat, le_s_cyc);
        end
        checks++;
        if (be_m_ack !== 1'b1 || be_m_dat !== 32'h00112200) begin
            errors++;
            $display("FAIL be_read_data got ack %b dat %h, want 1 00112200", be_m_ack, be_m_dat);
        end
        idle_master();
        tick();
    endtask

    task automatic test_sel_zero();
        m_adr = 32'h30; m_sel = 4'b0000; m_we = 1'b0;
        m_cyc = 1'b1; m_stb = 1'b1;
        checks++;
        if (be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL sel0_idle_cyc got %b want 0", be_s_cyc);
        end
        tick();
        checks++;
        if (be_m_ack !== 1'b1 || be_s_cyc !== 1'b0 || be_m_dat !== 32'h0) begin
            errors++;
            $display("FAIL sel0_ack got ack %b cyc %b dat %h, want 1 0 00000000", be_m_ack, be_s_cyc, be_m_dat);
        end
        idle_master();
        tick();
        checks++;
        if (be_m_ack !== 1'b0 || be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL sel0_after got ack %b cyc %b, want 0 0", be_m_ack, be_s_cyc);
        end
    endtask

    task automatic test_error();
        m_adr = 32'h100; m_dat = 32'h01020304; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1;
        tick();
        tick();
        checks++;
        if (be_s_adr !== 32'h101 || be_s_dat !== 8'h02) begin
            errors++;
            $display("FAIL err_offset1 got adr %h dat %h, want 101 02", be_s_adr, be_s_dat);
        end
        s_err = 1'b1;
        tick();
        checks++;
        if (be_m_err !== 1'b1 || be_m_ack !== 1'b0 || be_m_rty !== 1'b0 || be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL err_response got err %b ack %b rty %b cyc %b, want 1 0 0 0", be_m_err, be_m_ack, be_m_rty, be_s_cyc);
        end
        idle_master();
        tick();
        checks++;
        if (be_m_err !== 1'b0 || be_m_ack !== 1'b0 || be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL err_after got err %b ack %b cyc %b, want 0 0 0", be_m_err, be_m_ack, be_s_cyc);
        end
    endtask

    task automatic test_retry();
        m_adr = 32'h200; m_dat = 32'h0000BEEF; m_sel = 4'b0011; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        checks++;
        if (le_s_adr !== 32'h200 || le_s_dat !== 8'hEF) begin
            errors++;
            $display("FAIL rty_first got adr %h dat %h, want 200 EF", le_s_adr, le_s_dat);
        end
        s_rty = 1'b1; s_ack = 1'b1;
        tick();
        checks++;
        if (le_m_rty !== 1'b1 || le_m_ack !== 1'b0 || le_m_err !== 1'b0) begin
            errors++;
            $display("FAIL rty_response got rty %b ack %b err %b, want 1 0 0", le_m_rty, le_m_ack, le_m_err);
        end
        idle_master();
        tick();
        checks++;
        if (le_m_rty !== 1'b0 || le_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL rty_after got rty %b cyc %b, want 0 0", le_m_rty, le_s_cyc);
        end
    endtask

    task automatic test_cyc_drop();
        m_adr = 32'h300; m_sel = 4'hF; m_we = 1'b0;
        m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        tick();
        checks++;
        if (be_s_cyc !== 1'b1 || be_s_adr !== 32'h300) begin
            errors++;
            $display("FAIL drop_waiting got cyc %b adr %h, want 1 300", be_s_cyc, be_s_adr);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        #1;
        checks++;
        if (be_s_cyc !== 1'b0 || be_s_stb !== 1'b0) begin
            errors++;
            $display("FAIL drop_same_cycle got cyc %b stb %b, want 0 0", be_s_cyc, be_s_stb);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({be_m_ack, be_m_err, be_m_rty, be_s_cyc} !== 4'b0) begin
                errors++;
                $display("FAIL drop_no_resp cycle%0d got ack %b err %b rty %b cyc %b, want 0", i, be_m_ack, be_m_err, be_m_rty, be_s_cyc);
            end
        end
        m_adr = 32'h44; m_sel = 4'b0001; m_we = 1'b0;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1; s_dat = 8'h5A;
        tick();
        checks++;
        if (be_s_adr !== 32'h47 || be_s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL drop_next_adr got adr %h cyc %b, want 47 1", be_s_adr, be_s_cyc);
        end
        tick();
        checks++;
        if (be_m_ack !== 1'b1 || be_m_dat !== 32'h0000005A) begin
            errors++;
            $display("FAIL drop_next_ack got ack %b dat %h, want 1 0000005A", be_m_ack, be_m_dat);
        end
        idle_master();
        tick();
    endtask

    task automatic test_async_reset();
        m_adr = 32'h100; m_dat = 32'hAABBCCDD; m_sel = 4'hF; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1;
        tick();
        tick();
        checks++;
        if (be_s_cyc !== 1'b1 || be_s_adr !== 32'h101) begin
            errors++;
            $display("FAIL arst_pre got cyc %b adr %h, want 1 101", be_s_cyc, be_s_adr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({be_m_dat, be_m_ack, be_m_err, be_m_rty, be_s_adr, be_s_dat, be_s_we, be_s_cyc, be_s_stb} !== '0) begin
            errors++;
            $display("FAIL arst_outputs got mdat %h ack %b adr %h sdat %h we %b cyc %b, want all 0",
                     be_m_dat, be_m_ack, be_s_adr, be_s_dat, be_s_we, be_s_cyc);
        end
        idle_master();
        tick();
        rst_n = 1'b1;
        m_sel = 4'b0000; m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        checks++;
        if (be_m_ack !== 1'b1 || be_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle_after got ack %b cyc %b, want 1 0", be_m_ack, be_s_cyc);
        end
        idle_master();
        tick();
    endtask

    initial begin
        test_reset();
        test_be_write();
        test_le_read();
        test_sel_zero();
        test_error();
        test_retry();
        test_cyc_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
